edf_queue_reader: RTL and testbench
===================================

Name: edf_queue_reader

Overview:
- Read-side engine for the shared-buffer queueing domain.
- Tracks a relative-deadline countdown per queue and selects the non-empty queue with the earliest deadline (EDF).
- Drives the domain's core_id so the buffer read port returns that queue's head packet, waits out the buffer read latency, captures the packet and pulses that queue's consumed bit.
- Presents the packet downstream on a valid/ready handshake toward the memory-side master.

Parameters:
- NUMBER_OF_QUEUES, 4, number of per-core queues served.
- REGISTER_SIZE, 32, width of period registers and deadline counters.
- DATA_SIZE, 678, packet width, same as the buffer width.
- READ_LATENCY, 2, cycles from a stable core_id to valid data on queues_to_selector_packets; legal range 1..4.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- queues_period  in  [NUMBER_OF_QUEUES][REGISTER_SIZE]  relative deadline per queue, in cycles.
- empty  in  NUMBER_OF_QUEUES  per-queue empty flags from the queueing domain.
- queues_to_selector_packets  in  DATA_SIZE  buffer read data.
- core_id  out  $clog2(NUMBER_OF_QUEUES)  queue whose head is being read.
- scheduler_to_queues_consumed  out  NUMBER_OF_QUEUES  one-hot pop pulse.
- m_packet  out  DATA_SIZE  captured packet.
- m_queue_id  out  $clog2(NUMBER_OF_QUEUES)  source queue of m_packet.
- m_valid  out  1  packet valid.
- m_ready  in  1  downstream accept.
- deadline_miss  out  NUMBER_OF_QUEUES  one-cycle pulse per queue whose deadline expires.

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; core_id, consumed, m_valid, m_packet, m_queue_id, deadline_miss and all counters go to 0. Reset asserted mid-transaction abandons it: no consumed pulse and no m_valid.
- Deadline counter i, evaluated each cycle in priority order:
  - empty[i]=1 or consumed[i]=1: load queues_period[i].
  - otherwise, if the counter is >0: decrement by 1.
  - otherwise: hold at 0, saturating with no wrap.
  - deadline_miss[i] pulses on the cycle the counter goes from 1 to 0 while empty[i]=0.
- A queue that is non-empty on the first cycle after reset starts with counter 0 and is most urgent. This is intended.
- Selection is combinational. The winner is the non-empty queue with the minimum counter; ties go to the lowest index. A period of 0 means always most urgent.
- FSM states:
  - IDLE: if any empty[i]=0, register winner into core_id and m_queue_id, load wait counter with READ_LATENCY, go to WAIT.
  - WAIT: core_id held; wait counter decrements; when it reaches 1, go to CAPTURE. Total WAIT time is READ_LATENCY cycles.
  - CAPTURE: core_id still held (the availability pool recycles the address using the head pointer selected by core_id). scheduler_to_queues_consumed[core_id]=1 for exactly this cycle. At the end of this cycle, m_packet <= queues_to_selector_packets and m_valid <= 1. Go to OUTPUT.
  - OUTPUT: m_valid, m_packet and m_queue_id are held stable until m_ready=1. On the accepting edge, m_valid <= 0 and the FSM goes to IDLE.
- Output timing: m_valid is registered; there is no combinational path from m_ready to m_valid.
- Throughput: one packet per READ_LATENCY+3 cycles minimum. No new selection starts until the current packet has been accepted.
- A consumed pulse is never issued for an empty queue, and at most one consumed bit is set per cycle.
- The winner cannot become empty during WAIT, since only this block pops.
- Changes to queues_period take effect at the next reload only.

Decomposition:
- Shared package: FSM state enum (IDLE, WAIT, CAPTURE, OUTPUT) and the queue-index width constant, localparam IDX_W = $clog2(NUMBER_OF_QUEUES).
- One sub-module, edf_min_selector. Purely combinational. Inputs: counters and empty. Outputs: winner index and an any_ready flag. Implemented as a tree or linear min with lowest-index tie-break.
- Deadline counters and the FSM stay in edf_queue_reader.

Test Plan:
- Single queue, period[2]=10, READ_LATENCY=2: empty=4'b1011, m_ready=1 → core_id=2 from the cycle after IDLE; consumed=4'b0100 pulses exactly 3 cycles later; m_valid rises the next cycle with m_packet equal to the buffer data presented during CAPTURE, and m_queue_id=2.
- EDF order, periods {40,5,20,30}: all four queues go non-empty on the same cycle → service order 1,2,3,0. Each consumed is one-hot and one cycle wide.
- Tie-break, equal periods 8, queues 0 and 3 non-empty from the same cycle → queue 0 is served first.
- Backpressure: m_ready=0 for 20 cycles → m_valid held at 1, m_packet stable, no further consumed pulses, core_id unchanged; m_ready=1 → one accept, FSM returns to IDLE.
- Deadline miss: period[1]=3, queue 1 non-empty while backpressure blocks service → deadline_miss[1] pulses once, 3 cycles after loading; counter then stays at 0 with no further pulse.
- Reset during WAIT → consumed stays 0, m_valid stays 0, all counters 0; after release the pending queue is re-selected and served normally.

Source files
------------

// File: rtl/edf_queue_reader_pkg.sv
// edf_queue_reader_pkg: shared FSM encoding and queue-index widths for the EDF read engine
package edf_queue_reader_pkg;
    localparam int DEF_QUEUES = 4;
    localparam int IDX_W = $clog2(DEF_QUEUES);
    localparam int WAIT_W = 3;
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, OUTPUT} state_e;
endpackage

// File: rtl/edf_queue_reader_min_selector.sv
// edf_min_selector: picks the non-empty queue with the smallest deadline counter, lowest index on ties
module edf_min_selector
    import edf_queue_reader_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = DEF_QUEUES,
    parameter int REGISTER_SIZE = 32,
    parameter int IW = IDX_W
) (
    input  logic [REGISTER_SIZE-1:0]    counters [NUMBER_OF_QUEUES],
    input  logic [NUMBER_OF_QUEUES-1:0] empty,
    output logic [IW-1:0]               winner,
    output logic                        any_ready
);
    logic [REGISTER_SIZE-1:0] best_cnt;
    always_comb begin
        winner = '0;
        best_cnt = '0;
        any_ready = 1'b0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (!empty[i] && (!any_ready || counters[i] < best_cnt)) begin
                winner = IW'(i);
                best_cnt = counters[i];
                any_ready = 1'b1;
            end
        end
    end
endmodule

// File: rtl/edf_queue_reader.sv
// edf_queue_reader: EDF queue selection, buffer read sequencing and valid/ready packet output
module edf_queue_reader
    import edf_queue_reader_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = DEF_QUEUES,
    parameter int REGISTER_SIZE = 32,
    parameter int DATA_SIZE = 678,
    parameter int READ_LATENCY = 2,
    localparam int IW = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [REGISTER_SIZE-1:0]    queues_period [NUMBER_OF_QUEUES],
    input  logic [NUMBER_OF_QUEUES-1:0] empty,
    input  logic [DATA_SIZE-1:0]        queues_to_selector_packets,
    output logic [IW-1:0]               core_id,
    output logic [NUMBER_OF_QUEUES-1:0] scheduler_to_queues_consumed,
    output logic [DATA_SIZE-1:0]        m_packet,
    output logic [IW-1:0]               m_queue_id,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [NUMBER_OF_QUEUES-1:0] deadline_miss
);
    state_e state_q, state_d;
    logic [IW-1:0] core_id_q, core_id_d, m_queue_id_q, m_queue_id_d, winner;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DATA_SIZE-1:0] m_packet_q, m_packet_d;
    logic m_valid_q, m_valid_d, any_ready;
    logic [NUMBER_OF_QUEUES-1:0] consumed, miss_q, miss_d;
    logic [REGISTER_SIZE-1:0] cnt_q [NUMBER_OF_QUEUES];
    logic [REGISTER_SIZE-1:0] cnt_d [NUMBER_OF_QUEUES];

    edf_min_selector #(
        .NUMBER_OF_QUEUES(NUMBER_OF_QUEUES),
        .REGISTER_SIZE(REGISTER_SIZE),
        .IW(IW)
    ) u_sel (
        .counters(cnt_q),
        .empty(empty),
        .winner(winner),
        .any_ready(any_ready)
    );

    // a reset landing on the capture cycle must not pop the queue
    assign consumed = (state_q == CAPTURE && !reset) ? NUMBER_OF_QUEUES'(1) << core_id_q : '0;

    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            cnt_d[i] = (empty[i] || consumed[i]) ? queues_period[i] :
                       (cnt_q[i] != '0) ? cnt_q[i] - REGISTER_SIZE'(1) : '0;
            miss_d[i] = !empty[i] && !consumed[i] && cnt_q[i] == REGISTER_SIZE'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        core_id_d = core_id_q;
        m_queue_id_d = m_queue_id_q;
        wait_d = wait_q;
        m_packet_d = m_packet_q;
        m_valid_d = m_valid_q;
        case (state_q)
            IDLE: if (any_ready) begin
                state_d = WAIT;
                core_id_d = winner;
                m_queue_id_d = winner;
                wait_d = WAIT_W'(READ_LATENCY);
            end
            WAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                state_d = (wait_q == WAIT_W'(1)) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                m_packet_d = queues_to_selector_packets;
                m_valid_d = 1'b1;
                state_d = OUTPUT;
            end
            OUTPUT: if (m_ready) begin
                m_valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            core_id_q <= '0;
            m_queue_id_q <= '0;
            wait_q <= '0;
            m_packet_q <= '0;
            m_valid_q <= 1'b0;
            miss_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            core_id_q <= core_id_d;
            m_queue_id_q <= m_queue_id_d;
            wait_q <= wait_d;
            m_packet_q <= m_packet_d;
            m_valid_q <= m_valid_d;
            miss_q <= miss_d;
            cnt_q <= cnt_d;
        end
    end

    assign core_id = core_id_q;
    assign m_queue_id = m_queue_id_q;
    assign m_packet = m_packet_q;
    assign m_valid = m_valid_q;
    assign deadline_miss = miss_q;
    assign scheduler_to_queues_consumed = consumed;
endmodule

// File: tb/tb_edf_queue_reader.sv
// tb_edf_queue_reader: randomized and directed checks against a transaction-timeline model
module tb_edf_queue_reader;
    localparam int N = 4, R = 32, D = 678, L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, m_ready, m_valid;
    logic [R-1:0] queues_period [N];
    logic [N-1:0] empty, consumed, deadline_miss;
    logic [D-1:0] queues_to_selector_packets, m_packet;
    logic [1:0] core_id, m_queue_id;

    edf_queue_reader #(
        .NUMBER_OF_QUEUES(N),
        .REGISTER_SIZE(R),
        .DATA_SIZE(D),
        .READ_LATENCY(L)
    ) dut (
        .clock(clk),
        .reset(reset),
        .queues_period(queues_period),
        .empty(empty),
        .queues_to_selector_packets(queues_to_selector_packets),
        .core_id(core_id),
        .scheduler_to_queues_consumed(consumed),
        .m_packet(m_packet),
        .m_queue_id(m_queue_id),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .deadline_miss(deadline_miss)
    );

    int checks = 0, errors = 0;
    int occ [N];
    int dl [N];
    logic [N-1:0] mmiss;
    bit busy;
    int age, sel;
    logic [D-1:0] mpkt, pkt_next, saved_pkt;
    logic [1:0] exp_core;
    logic [N-1:0] exp_cons, exp_miss;
    logic exp_val;
    logic [D-1:0] exp_pkt;
    bit chk_on = 0;
    int got [8];
    int ngot, misses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [D-1:0] rnd_pkt();
        logic [D-1:0] p = '0;
        for (int k = 0; k < 22; k++) p = (p << 32) | D'($urandom);
        return p;
    endfunction

    always @(negedge clk) if (chk_on) begin
        chk("core_id", 32'(core_id), 32'(exp_core));
        chk("m_queue_id", 32'(m_queue_id), 32'(exp_core));
        chk("consumed", 32'(consumed), 32'(exp_cons));
        chk("m_valid", 32'(m_valid), 32'(exp_val));
        chk("deadline_miss", 32'(deadline_miss), 32'(exp_miss));
        chk("consumed_onehot", 32'($countones(consumed) <= 1), 32'(1));
        checks++;
        if (m_packet !== exp_pkt) begin
            errors++;
            $display("FAIL m_packet actual=%h required=%h", m_packet, exp_pkt);
        end
    end

    // Service timeline: age 1..L reading, L+1 capture, >= L+2 presenting
    task automatic model_update();
        int best = -1;
        logic [N-1:0] nm;
        if (reset) begin
            for (int i = 0; i < N; i++) dl[i] = 0;
            mmiss = '0;
            busy = 0;
            age = 0;
            sel = 0;
            mpkt = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (!empty[i] && (best < 0 || dl[i] < dl[best])) best = i;
            for (int i = 0; i < N; i++) begin
                nm[i] = !empty[i] && !exp_cons[i] && dl[i] == 1;
                dl[i] = (empty[i] || exp_cons[i]) ? int'(queues_period[i]) : (dl[i] > 0 ? dl[i] - 1 : 0);
                if (exp_cons[i]) occ[i]--;
            end
            mmiss = nm;
            if (!busy) begin
                if (best >= 0) begin
                    busy = 1;
                    age = 1;
                    sel = best;
                end
            end else if (age == L + 1) begin
                mpkt = queues_to_selector_packets;
                age++;
            end else if (age >= L + 2 && m_ready) busy = 0;
            else age++;
        end
    endtask

    task automatic step();
        for (int i = 0; i < N; i++) empty[i] = (occ[i] == 0);
        queues_to_selector_packets = pkt_next;
        exp_core = 2'(sel);
        exp_cons = (busy && age == L + 1 && !reset) ? 4'(1) << sel : 4'b0;
        exp_val = busy && age >= L + 2;
        exp_pkt = mpkt;
        exp_miss = mmiss;
        @(posedge clk);
        model_update();
        #1;
        pkt_next = rnd_pkt();
    endtask

    task automatic collect(input int n);
        bit pv = 0;
        ngot = 0;
        for (int c = 0; c < 40 * n && ngot < n; c++) begin
            step();
            if (m_valid && !pv && ngot < 8) begin
                got[ngot] = int'(m_queue_id);
                ngot++;
            end
            pv = m_valid;
        end
    endtask

    initial begin
        logic [D-1:0] d1;
        d1 = {339{2'b10}};
        reset = 1;
        m_ready = 1;
        for (int i = 0; i < N; i++) begin
            queues_period[i] = 10;
            occ[i] = 0;
            dl[i] = 0;
        end
        busy = 0; age = 0; sel = 0; mpkt = '0; mmiss = '0;
        pkt_next = rnd_pkt();
        step();
        step();
        chk_on = 1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_core_id", 32'(core_id), 0);
        chk("rst_consumed", 32'(consumed), 0);
        chk("rst_miss", 32'(deadline_miss), 0);
        chk("rst_m_packet", 32'(|m_packet), 0);

        // single queue, period 10
        reset = 0;
        occ[2] = 1;
        step();
        chk("t1_core_id", 32'(core_id), 2);
        chk("t1_cons_wait", 32'(consumed), 0);
        step();
        step();
        chk("t1_consumed", 32'(consumed), 32'h4);
        pkt_next = d1;
        step();
        chk("t1_m_valid", 32'(m_valid), 1);
        chk("t1_qid", 32'(m_queue_id), 2);
        chk("t1_pkt", 32'(m_packet === d1), 1);
        chk("t1_cons_after", 32'(consumed), 0);
        step();
        chk("t1_accept", 32'(m_valid), 0);

        // EDF order
        queues_period[0] = 40; queues_period[1] = 5; queues_period[2] = 20; queues_period[3] = 30;
        step();
        step();
        for (int i = 0; i < N; i++) occ[i] = 1;
        collect(4);
        chk("t2_count", ngot, 4);
        chk("t2_order0", got[0], 1);
        chk("t2_order1", got[1], 2);
        chk("t2_order2", got[2], 3);
        chk("t2_order3", got[3], 0);

        // tie-break
        for (int i = 0; i < N; i++) queues_period[i] = 8;
        step();
        step();
        occ[0] = 1; occ[3] = 1;
        collect(2);
        chk("t3_count", ngot, 2);
        chk("t3_first", got[0], 0);
        chk("t3_second", got[1], 3);

        // backpressure with a deadline miss on queue 1
        queues_period[0] = 0; queues_period[1] = 3; queues_period[2] = 9; queues_period[3] = 9;
        step();
        step();
        m_ready = 0;
        occ[0] = 1; occ[1] = 1;
        misses = 0;
        saved_pkt = '0;
        for (int s = 1; s <= 25; s++) begin
            step();
            if (deadline_miss[1]) misses++;
            if (s == 1) chk("t4_core_id", 32'(core_id), 0);
            if (s == 3) chk("t4_miss_at3", 32'(deadline_miss), 32'h2);
            if (s == 4) saved_pkt = m_packet;
            if (s >= 5) begin
                chk("t4_valid_held", 32'(m_valid), 1);
                chk("t4_pkt_stable", 32'(m_packet === saved_pkt), 1);
                chk("t4_no_pop", 32'(consumed), 0);
                chk("t4_core_held", 32'(core_id), 0);
            end
        end
        chk("t4_miss_count", misses, 1);
        m_ready = 1;
        step();
        chk("t4_accept", 32'(m_valid), 0);
        collect(1);
        chk("t4_next_q1", got[0], 1);
        step();

        // reset during WAIT
        occ[3] = 1;
        step();
        step();
        reset = 1;
        step();
        chk("t5_valid", 32'(m_valid), 0);
        chk("t5_consumed", 32'(consumed), 0);
        chk("t5_core_id", 32'(core_id), 0);
        chk("t5_occ_kept", occ[3], 1);
        reset = 0;
        collect(1);
        chk("t5_reserved", ngot, 1);
        chk("t5_qid", got[0], 3);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0 && occ[i] < 5) occ[i]++;
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) queues_period[$urandom_range(0, 3)] = R'($urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
